// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from EX/MEM and MEM/WB.
// Drives the ALU operands, the ALU opcode and the store data for the current EX instruction.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     id_rd1,
  input  logic [DATA_WIDTH-1:0]     id_rd2,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [2:0]                id_alu_control,
  input  logic                      id_alu_src,
  input  logic                      id_reg_dst,
  input  logic                      id_reg_write,
  input  logic                      id_mem_write,
  input  logic                      id_mem_to_reg,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
  input  logic [DATA_WIDTH-1:0]     mem_alu_result,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     srcA,
  output logic [DATA_WIDTH-1:0]     srcB,
  output logic [2:0]                alu_control,
  output logic [DATA_WIDTH-1:0]     ex_write_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_write_reg,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic                      ex_reg_write,
  output logic                      ex_mem_write,
  output logic                      ex_mem_to_reg
);

  logic [DATA_WIDTH-1:0]     rd1_reg, rd2_reg, imm_reg;
  logic [REG_ADDR_WIDTH-1:0] rs_reg, rt_reg, rd_reg;
  logic [2:0]                alu_control_reg;
  logic                      alu_src_reg, reg_dst_reg;
  logic                      reg_write_reg, mem_write_reg_q, mem_to_reg_reg;

  // A flush turns the slot into a bubble: control and register fields clear, data may stay stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd1_reg         <= '0;
      rd2_reg         <= '0;
      imm_reg         <= '0;
      rs_reg          <= '0;
      rt_reg          <= '0;
      rd_reg          <= '0;
      alu_control_reg <= '0;
      alu_src_reg     <= 1'b0;
      reg_dst_reg     <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_write_reg_q <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
    end else if (flush) begin
      rs_reg          <= '0;
      rt_reg          <= '0;
      rd_reg          <= '0;
      alu_control_reg <= '0;
      alu_src_reg     <= 1'b0;
      reg_dst_reg     <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_write_reg_q <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
    end else if (!stall) begin
      rd1_reg         <= id_rd1;
      rd2_reg         <= id_rd2;
      imm_reg         <= id_imm;
      rs_reg          <= id_rs;
      rt_reg          <= id_rt;
      rd_reg          <= id_rd;
      alu_control_reg <= id_alu_control;
      alu_src_reg     <= id_alu_src;
      reg_dst_reg     <= id_reg_dst;
      reg_write_reg   <= id_reg_write;
      mem_write_reg_q <= id_mem_write;
      mem_to_reg_reg  <= id_mem_to_reg;
    end
  end

  logic [REG_ADDR_WIDTH-1:0] src_sel  [2];
  logic [DATA_WIDTH-1:0]     src_dflt [2];
  logic [DATA_WIDTH-1:0]     fwd      [2];

  assign src_sel[0]  = rs_reg;
  assign src_sel[1]  = rt_reg;
  assign src_dflt[0] = rd1_reg;
  assign src_dflt[1] = rd2_reg;

  // EX/MEM is checked first because it holds the newer value; $0 is never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit, wb_hit;
      assign mem_hit = (src_sel[gi] != '0) && mem_reg_write && (mem_write_reg == src_sel[gi]);
      assign wb_hit  = (src_sel[gi] != '0) && wb_reg_write  && (wb_write_reg  == src_sel[gi]);
      assign fwd[gi] = mem_hit ? mem_alu_result : (wb_hit ? wb_result : src_dflt[gi]);
    end
  endgenerate

  assign srcA          = fwd[0];
  assign srcB          = alu_src_reg ? imm_reg : fwd[1];
  assign ex_write_data = fwd[1];
  assign alu_control   = alu_control_reg;
  assign ex_write_reg  = reg_dst_reg ? rd_reg : rt_reg;
  assign ex_rs         = rs_reg;
  assign ex_rt         = rt_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_mem_write  = mem_write_reg_q;
  assign ex_mem_to_reg = mem_to_reg_reg;

endmodule
